// File: rtl/clt_noise_gen_if.sv
// Output sample channel of the CLT noise generator: a valid/ready handshake
// that carries one signed sample per transfer.
interface clt_noise_gen_if #(
  parameter int OUT_W = 32
);
  logic                    valid;
  logic                    ready;
  logic signed [OUT_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/clt_noise_gen.sv
// Central-limit-theorem noise source. NUM_SRC Galois LFSRs are summed, centred,
// scaled and saturated, and the result is offered on a valid/ready channel.
module clt_noise_gen #(
  parameter int          NUM_SRC  = 4,
  parameter int          SRC_W    = 16,
  parameter int          OUT_W    = 32,
  parameter int          SHIFT    = 0,
  parameter logic [31:0] SEED_RST = 32'h0000_0001
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_en,
  input  logic [15:0]        i_div,
  input  logic               i_seed_load,
  input  logic [31:0]        i_seed,
  clt_noise_gen_if.master    o_smp,
  output logic               o_overrun
);

  localparam int SUM_W = SRC_W + $clog2(NUM_SRC) + 1;
  localparam int CW    = SUM_W + 1;
  localparam int EW    = ((CW > OUT_W) ? CW : OUT_W) + 1;

  localparam logic [31:0] GOLD = 32'h9E37_79B9;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  localparam logic [CW-1:0]        MID     = CW'(NUM_SRC) << (SRC_W - 1);
  localparam logic signed [EW-1:0] SAT_MAX = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [EW-1:0] SAT_MIN = ~SAT_MAX;

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [31:0] chan_seed(input logic [31:0] s, input int idx);
    logic [31:0] v;
    v = s ^ (32'(idx + 1) * GOLD);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  logic [15:0]      r_cnt;
  logic             w_tick;
  logic             r_va;
  logic             r_vb;
  logic [SRC_W-1:0] w_chan [NUM_SRC];
  logic [SUM_W-1:0] w_sum;
  logic [SUM_W-1:0] r_sum;

  logic signed [CW-1:0]    w_centred;
  logic signed [CW-1:0]    w_scaled;
  logic signed [EW-1:0]    w_ext;
  logic signed [EW-1:0]    w_sat;
  logic                    w_xfer;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_overrun;

  // seed_load suppresses the tick so the reseed is never overwritten by a step.
  assign w_tick = i_en & (r_cnt == 16'd0) & ~i_seed_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_seed_load) begin
      r_cnt <= 16'd0;
    end else if (i_en) begin
      r_cnt <= w_tick ? i_div : r_cnt - 16'd1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_chan
      localparam logic [31:0] RST_VAL = chan_seed(SEED_RST, gi);
      logic [31:0] r_lfsr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_lfsr <= RST_VAL;
        end else if (i_seed_load) begin
          r_lfsr <= chan_seed(i_seed, gi);
        end else if (w_tick) begin
          r_lfsr <= {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? TAPS : 32'h0);
        end
      end

      assign w_chan[gi] = r_lfsr[SRC_W-1:0];
    end
  endgenerate

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_sum = w_sum + SUM_W'(w_chan[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_va  <= 1'b0;
      r_vb  <= 1'b0;
      r_sum <= '0;
    end else begin
      r_va  <= i_seed_load ? 1'b0 : w_tick;
      r_vb  <= i_seed_load ? 1'b0 : r_va;
      r_sum <= w_sum;
    end
  end

  assign w_centred = $signed({1'b0, r_sum} - MID);
  assign w_scaled  = w_centred >>> SHIFT;
  assign w_ext     = EW'(w_scaled);
  assign w_sat     = (w_ext > SAT_MAX) ? SAT_MAX :
                     (w_ext < SAT_MIN) ? SAT_MIN : w_ext;

  assign w_xfer = r_out_valid & o_smp.ready;

  // A result that finds the holding register occupied and not draining is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_overrun   <= 1'b0;
    end else if (i_seed_load) begin
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else if (r_vb) begin
      if (!r_out_valid || w_xfer) begin
        r_out_data  <= w_sat[OUT_W-1:0];
        r_out_valid <= 1'b1;
      end else begin
        r_overrun   <= 1'b1;
      end
    end else if (w_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_smp.valid = r_out_valid;
  assign o_smp.data  = r_out_data;
  assign o_overrun   = r_overrun;

endmodule
